// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared widths and entry layout for the branch trace unit (CPU_TRACE_RD_VAL_EN adds rd)
package cpu_trace_pkg;

    localparam int PC_W       = 16;
    localparam int DROP_CNT_W = 8;
    localparam int TS_W_DEF   = 16;

    // Entry layout at the default timestamp width; the top re-declares it for other TS_W values
    typedef struct packed {
        logic [PC_W-1:0]     from;
        logic [PC_W-1:0]     to;
        logic [TS_W_DEF-1:0] ts;
`ifdef CPU_TRACE_RD_VAL_EN
        logic [PC_W-1:0]     rd;
`endif
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through FIFO of trace entries with occupancy counter
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = trace_entry_t
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic                   full_o,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // valid/full come only from the registered count, so ready never reaches valid combinationally
    assign valid_o = (count != '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle
    assign do_push = push_i && (!full_o || do_pop);
    // Head is forced to zero while empty so all outputs read 0 after reset
    assign head_o  = valid_o ? mem[rd_ptr] : '0;
    assign count_o = count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk_i) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; unreset because the head is masked until a write has landed
    always_ff @(posedge clk_i) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/cpu_branch_trace.sv
// rtl/cpu_branch_trace.sv - captures non-sequential PC changes into a drainable trace FIFO (CPU_TRACE_RD_VAL_EN adds Rd_val capture)
module cpu_branch_trace
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [PC_W-1:0]        rd_val_i,
    input  logic                   enable_i,
    output logic                   tr_valid_o,
    input  logic                   tr_ready_i,
    output logic [PC_W-1:0]        tr_from_o,
    output logic [PC_W-1:0]        tr_to_o,
    output logic [TS_W-1:0]        tr_ts_o,
`ifdef CPU_TRACE_RD_VAL_EN
    output logic [PC_W-1:0]        tr_rd_o,
`endif
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

    typedef struct packed {
        logic [PC_W-1:0] from;
        logic [PC_W-1:0] to;
        logic [TS_W-1:0] ts;
`ifdef CPU_TRACE_RD_VAL_EN
        logic [PC_W-1:0] rd;
`endif
    } entry_t;

    logic [PC_W-1:0] prev_pc;
    logic            prev_vld;
    logic [TS_W-1:0] ts_cnt;
    logic            event_hit;
    logic            fifo_full;
    logic            drop;
    entry_t          new_entry;
    entry_t          head;

    // A jump is any PC change other than +1 (16-bit wrap) or a stall
    assign event_hit = prev_vld && enable_i
                    && (pc_i != prev_pc + PC_W'(1))
                    && (pc_i != prev_pc);

    // An event is lost only when full and the head is not leaving this cycle
    assign drop = event_hit && fifo_full && !(tr_valid_o && tr_ready_i);

    assign new_entry.from = prev_pc;
    assign new_entry.to   = pc_i;
    assign new_entry.ts   = ts_cnt;
`ifdef CPU_TRACE_RD_VAL_EN
    assign new_entry.rd   = rd_val_i;
`else
    logic unused_rd_val;
    assign unused_rd_val = ^rd_val_i;
`endif

    // PC history and timestamp keep running regardless of enable so re-enabling is glitch-free
    always_ff @(posedge clk_i) begin
        if (reset) begin
            prev_pc  <= '0;
            prev_vld <= 1'b0;
            ts_cnt   <= '0;
        end else begin
            prev_pc  <= pc_i;
            prev_vld <= 1'b1;
            ts_cnt   <= ts_cnt + TS_W'(1);
        end
    end

    // Sticky overflow and saturating drop counter
    always_ff @(posedge clk_i) begin
        if (reset) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
            end
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset       (reset),
        .push_i      (event_hit),
        .push_data_i (new_entry),
        .pop_i       (tr_ready_i),
        .valid_o     (tr_valid_o),
        .full_o      (fifo_full),
        .head_o      (head),
        .count_o     (count_o)
    );

    assign tr_from_o = head.from;
    assign tr_to_o   = head.to;
    assign tr_ts_o   = head.ts;
`ifdef CPU_TRACE_RD_VAL_EN
    assign tr_rd_o   = head.rd;
`endif

endmodule

// File: tb/tb_cpu_branch_trace.sv
// tb/tb_cpu_branch_trace.sv - scoreboard bench for cpu_branch_trace with a queue-based reference model
module tb_cpu_branch_trace;

    localparam int DEPTH = 8;
    localparam int TS_W  = 16;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_i = '0;
    logic [15:0] rd_val_i = '0;
    logic        enable_i = 1'b0;
    logic        tr_ready_i = 1'b0;
    logic        tr_valid_o;
    logic [15:0] tr_from_o;
    logic [15:0] tr_to_o;
    logic [15:0] tr_ts_o;
`ifdef CPU_TRACE_RD_VAL_EN
    logic [15:0] tr_rd_o;
`endif
    logic [3:0]  count_o;
    logic        overflow_o;
    logic [7:0]  drop_cnt_o;

    cpu_branch_trace #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .pc_i       (pc_i),
        .rd_val_i   (rd_val_i),
        .enable_i   (enable_i),
        .tr_valid_o (tr_valid_o),
        .tr_ready_i (tr_ready_i),
        .tr_from_o  (tr_from_o),
        .tr_to_o    (tr_to_o),
        .tr_ts_o    (tr_ts_o),
`ifdef CPU_TRACE_RD_VAL_EN
        .tr_rd_o    (tr_rd_o),
`endif
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] from;
        logic [15:0] to;
        logic [15:0] ts;
        logic [15:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          started = 0;
    logic [15:0] cur_pc = '0;

    // Reference model state: what the unit should hold, in plain counters
    int          m_prev = 0;
    bit          m_vld = 0;
    int          m_ts = 0;
    int          m_cnt = 0;
    bit          m_ovf = 0;
    int          m_drop = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Model: evaluate each clock edge from the inputs the bench applied
    initial forever begin
        bit   pop;
        bit   ev;
        exp_t e;
        @(posedge clk_i);
        if (reset) begin
            m_vld = 0; m_ts = 0; m_cnt = 0; m_ovf = 0; m_drop = 0; m_prev = int'(pc_i);
            sb.delete();
        end else begin
            pop = (m_cnt > 0) && tr_ready_i;
            ev  = m_vld && enable_i && (int'(pc_i) != m_prev)
                  && (int'(pc_i) != (m_prev + 1) % 65536);
            if (ev) begin
                if (m_cnt < DEPTH || pop) begin
                    e.from = 16'(m_prev); e.to = pc_i; e.ts = 16'(m_ts); e.rd = rd_val_i;
                    sb.push_back(e);
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (pop) m_cnt--;
            m_prev = int'(pc_i);
            m_vld  = 1;
            m_ts   = (m_ts + 1) % 65536;
        end
    end

    // Monitor: mid-cycle, compare status and any entry being handed over
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (started) begin
            check("count", 32'(count_o), 32'(m_cnt));
            check("valid", 32'(tr_valid_o), 32'(m_cnt != 0));
            check("overflow", 32'(overflow_o), 32'(m_ovf));
            check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
            if (tr_valid_o && tr_ready_i) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("head_from", 32'(tr_from_o), 32'(e.from));
                    check("head_to", 32'(tr_to_o), 32'(e.to));
                    check("head_ts", 32'(tr_ts_o), 32'(e.ts));
`ifdef CPU_TRACE_RD_VAL_EN
                    check("head_rd", 32'(tr_rd_o), 32'(e.rd));
`endif
                end
            end
        end
    end

    task automatic drive(input logic [15:0] pc, input bit en, input bit rdy, input bit rst);
        pc_i = pc; enable_i = en; tr_ready_i = rdy; reset = rst;
        rd_val_i = 16'($urandom);
        cur_pc = pc;
        @(posedge clk_i); #1;
    endtask

    task automatic seq(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(cur_pc + 16'd1, 1'b1, rdy, 1'b0);
    endtask

    task automatic jmp(input logic [15:0] to, input bit rdy);
        drive(to, 1'b1, rdy, 1'b0);
    endtask

    initial begin
        drive(16'd0, 1'b1, 1'b0, 1'b1);
        started = 1;
        drive(16'd0, 1'b1, 1'b0, 1'b1);
        check("reset_valid", 32'(tr_valid_o), 32'd0);
        check("reset_from", 32'(tr_from_o), 32'd0);

        // 0,1,2,3,4,35 from reset release
        for (int i = 0; i <= 4; i++) drive(16'(i), 1'b1, 1'b0, 1'b0);
        check("valid_before_jump", 32'(tr_valid_o), 32'd0);
        jmp(16'd35, 1'b0);
        check("first_valid", 32'(tr_valid_o), 32'd1);
        check("first_from", 32'(tr_from_o), 32'd4);
        check("first_to", 32'(tr_to_o), 32'd35);
        check("first_ts", 32'(tr_ts_o), 32'd5);
        seq(2, 1'b1);

        // stall at 60 then 61 then 46
        jmp(16'd60, 1'b0);
        drive(16'd60, 1'b1, 1'b0, 1'b0);
        drive(16'd60, 1'b1, 1'b0, 1'b0);
        seq(1, 1'b0);
        jmp(16'd46, 1'b0);
        check("stall_count", 32'(count_o), 32'd2);
        seq(3, 1'b1);

        // 0xFFFF -> 0x0000 is sequential
        jmp(16'hFFFF, 1'b1);
        seq(3, 1'b1);
        check("wrap_count", 32'(count_o), 32'd0);

        // overflow with 10 jumps into DEPTH 8
        for (int i = 0; i < 10; i++) jmp(16'(1000 + 10 * i), 1'b0);
        check("ovf_count", 32'(count_o), 32'd8);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_drop", 32'(drop_cnt_o), 32'd2);
        jmp(16'd5000, 1'b1);
        check("full_pushpop_count", 32'(count_o), 32'd8);
        check("full_pushpop_drop", 32'(drop_cnt_o), 32'd2);
        seq(10, 1'b1);

        // disabled jump then re-enable
        drive(16'd17, 1'b0, 1'b1, 1'b0);
        drive(16'd35, 1'b0, 1'b1, 1'b0);
        seq(3, 1'b0);
        check("disabled_count", 32'(count_o), 32'd0);
        jmp(16'd90, 1'b0);
        check("reenable_count", 32'(count_o), 32'd1);
        seq(2, 1'b1);

        // reset mid-drain
        jmp(16'd300, 1'b0);
        jmp(16'd400, 1'b0);
        jmp(16'd500, 1'b0);
        drive(16'd501, 1'b1, 1'b1, 1'b1);
        check("rst_drain_valid", 32'(tr_valid_o), 32'd0);
        check("rst_drain_count", 32'(count_o), 32'd0);
        drive(16'd777, 1'b1, 1'b1, 1'b0);
        seq(1, 1'b1);
        check("post_rst_count", 32'(count_o), 32'd0);
        check("post_rst_valid", 32'(tr_valid_o), 32'd0);

        // drop counter saturation
        for (int i = 0; i < 270; i++) jmp(16'((i % 2) ? 100 : 200), 1'b0);
        check("drop_saturate", 32'(drop_cnt_o), 32'd255);
        seq(10, 1'b1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int  r;
            bit  en;
            bit  rdy;
            r   = int'($urandom_range(0, 9));
            en  = $urandom_range(0, 7) != 0;
            rdy = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 299) == 0) drive(cur_pc, en, rdy, 1'b1);
            else if (r < 5) drive(cur_pc + 16'd1, en, rdy, 1'b0);
            else if (r == 5) drive(cur_pc, en, rdy, 1'b0);
            else drive(16'($urandom), en, rdy, 1'b0);
        end

        seq(20, 1'b1);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
